multu_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the unsigned MULTU path and owner of the HI/LO pair.
//  - Accepts MULTU issue from the decode stage and runs a WIDTH-step shift-add multiply.
//  - Commits the product to HI/LO and serves MFHI/MFLO reads.
//  - Raises stall to freeze PC/decode while a hazard exists. Sits beside the ALU.

---
 rtl/multu_seq_ctrl_pkg.sv | 18 +
 rtl/multu_seq_ctrl_mul_shift_add.sv | 58 +++++
 rtl/multu_seq_ctrl.sv | 93 +++++++++
 tb/tb_multu_seq_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/multu_seq_ctrl_pkg.sv
// Shared encodings for the MULTU sequencer: ALU result select codes, FSM states
// and a decode helper for HI/LO reads.
package multu_seq_ctrl_pkg;

  localparam logic [1:0] ALUSEL_ALU  = 2'b00;
  localparam logic [1:0] ALUSEL_MFHI = 2'b01;
  localparam logic [1:0] ALUSEL_MFLO = 2'b10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MUL    = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  // True when the decoded instruction reads HI or LO (MFHI/MFLO).
  function automatic logic reads_hilo(input logic [1:0] alusel);
    return (alusel == ALUSEL_MFHI) || (alusel == ALUSEL_MFLO);
  endfunction

endpackage

// File: rtl/multu_seq_ctrl_mul_shift_add.sv
// Shift-add multiplier datapath: product/multiplicand registers, the WIDTH+1-bit
// adder and the iteration counter. Sequenced externally through load and step.
module mul_shift_add #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;

  // The adder carry becomes the new MSB, so the full 2*WIDTH product stays exact.
  always_comb begin
    addend = prod_q[0] ? mcand_q : '0;
    sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  end

  always_comb begin
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    if (load) begin
      mcand_d = a;
      prod_d  = {{WIDTH{1'b0}}, b};
      cnt_d   = '0;
    end else if (step) begin
      prod_d = {sum, prod_q[WIDTH-1:1]};
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last    = (cnt_q == CNT_W'(WIDTH - 1));
  assign product = prod_q;

endmodule

// File: rtl/multu_seq_ctrl.sv
// MULTU sequencer and HI/LO owner: runs the multiply in the background, commits
// the product to HI/LO, serves MFHI/MFLO and stalls decode on HI/LO hazards.
module multu_seq_ctrl
  import multu_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic             multu,
  input  logic [1:0]       alusel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hilo_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               load, step, commit, last;
  logic [2*WIDTH-1:0] product;

  mul_shift_add #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .a       (a),
    .b       (b),
    .last    (last),
    .product (product)
  );

  assign load   = issue & multu & (state_q == S_IDLE);
  assign step   = (state_q == S_MUL);
  assign commit = (state_q == S_COMMIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (load) state_d = S_MUL;
      S_MUL:    if (last) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Reset wins over commit, so an aborted multiply never reaches HI/LO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= commit;
      if (commit) begin
        hi_q <= product[2*WIDTH-1:WIDTH];
        lo_q <= product[WIDTH-1:0];
      end
    end
  end

  assign busy  = (state_q != S_IDLE);
  // The accepting MULTU sees busy=0, so it never stalls itself.
  assign stall = issue & busy & (multu | reads_hilo(alusel));

  always_comb begin
    hilo_out = '0;
    case (alusel)
      ALUSEL_MFHI: hilo_out = hi_q;
      ALUSEL_MFLO: hilo_out = lo_q;
      ALUSEL_ALU:  hilo_out = '0;
      default:     hilo_out = '0;
    endcase
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule

// File: tb/tb_multu_seq_ctrl.sv
// Self-checking bench for multu_seq_ctrl: directed scenarios plus random traffic,
// compared every cycle against a timeline model of accept/busy/commit.
module tb_multu_seq_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n, issue, multu;
  logic [1:0]    alusel;
  logic [W-1:0]  a, b, hilo_out, hi, lo;
  logic          busy, stall, done;

  multu_seq_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue    (issue),
    .multu    (multu),
    .alusel   (alusel),
    .a        (a),
    .b        (b),
    .hilo_out (hilo_out),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall    (stall),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: an accepted MULTU in cycle acc keeps the unit busy for cycles
  // acc+1..acc+W+1; the product shows on HI/LO with done in cycle acc+W+2.
  int            k   = 0;
  int            acc = -1000;
  logic [2*W-1:0] pend = '0;
  logic [W-1:0]  m_hi = '0, m_lo = '0;

  logic          obs_busy, obs_stall, obs_done;
  logic [W-1:0]  obs_hi, obs_lo, obs_hilo;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic cycle(input logic iss, input logic mu, input logic [1:0] sel,
                       input logic [W-1:0] av, input logic [W-1:0] bv, input logic rn);
    logic         m_busy, m_stall, m_done;
    logic [W-1:0] m_hilo;
    issue  = iss;
    multu  = mu;
    alusel = sel;
    a      = av;
    b      = bv;
    rst_n  = rn;
    m_busy  = (k > acc) && (k <= acc + W + 1);
    m_done  = (k == acc + W + 2);
    m_stall = iss && m_busy && (mu || sel == 2'b01 || sel == 2'b10);
    m_hilo  = (sel == 2'b01) ? m_hi : (sel == 2'b10) ? m_lo : '0;
    #1;
    chk("busy", busy, m_busy);
    chk("stall", stall, m_stall);
    chk("done", done, m_done);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("hilo_out", hilo_out, m_hilo);
    obs_busy  = busy;
    obs_stall = stall;
    obs_done  = done;
    obs_hi    = hi;
    obs_lo    = lo;
    obs_hilo  = hilo_out;
    @(posedge clk);
    #1;
    if (!rn) begin
      m_hi = '0;
      m_lo = '0;
      acc  = -1000;
    end else if (iss && mu && !m_busy) begin
      acc  = k;
      pend = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
    end
    k++;
    if (k == acc + W + 2) {m_hi, m_lo} = pend;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, '0, '0, 1'b1);
  endtask

  // Decode holds the instruction while stalled; bounded so the bench cannot hang.
  task automatic hold_issue(input logic mu, input logic [1:0] sel, input logic [W-1:0] av,
                            input logic [W-1:0] bv, output int nstall);
    nstall = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, mu, sel, av, bv, 1'b1);
      if (!obs_stall) return;
      nstall++;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL hold_timeout: still stalled after %0d cycles, required release", nstall);
  endtask

  task automatic run_mul(input logic [W-1:0] av, input logic [W-1:0] bv);
    cycle(1'b1, 1'b1, 2'b00, av, bv, 1'b1);
    idle(W + 3);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  int busy_cnt, done_at, done_cnt, ns;

  initial begin
    rst_n = 1'b0; issue = 1'b0; multu = 1'b0; alusel = 2'b00; a = '0; b = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
    chk("reset_busy", obs_busy, 0);

    // 1: 3*5, latency and busy window
    cycle(1'b1, 1'b1, 2'b00, 32'd3, 32'd5, 1'b1);
    busy_cnt = 0;
    done_at  = -1;
    for (int i = 1; i <= 40; i++) begin
      idle(1);
      if (obs_busy) busy_cnt++;
      if (obs_done) done_at = i;
    end
    chk("t1_hi", obs_hi, 0);
    chk("t1_lo", obs_lo, 15);
    chk("t1_busy_cycles", busy_cnt, W + 1);
    chk("t1_done_offset", done_at, W + 2);

    // 2: extremes
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("t2_hi_max", obs_hi, 32'hFFFF_FFFE);
    chk("t2_lo_max", obs_lo, 32'h0000_0001);
    run_mul(32'h0, 32'hDEAD_BEEF);
    chk("t2_hi_zero", obs_hi, 0);
    chk("t2_lo_zero", obs_lo, 0);

    // 3: MFLO right behind MULTU waits for the commit
    cycle(1'b1, 1'b1, 2'b00, 32'd7, 32'd6, 1'b1);
    hold_issue(1'b0, 2'b10, '0, '0, ns);
    chk("t3_stall_cycles", ns, W + 1);
    chk("t3_hilo", obs_hilo, 42);
    idle(2);

    // 4: back-to-back MULTU
    cycle(1'b1, 1'b1, 2'b00, 32'd2, 32'd2, 1'b1);
    hold_issue(1'b1, 2'b00, 32'd10, 32'd10, ns);
    chk("t4_stall_cycles", ns, W + 1);
    chk("t4_done1", obs_done, 1);
    chk("t4_lo1", obs_lo, 4);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (obs_done) done_cnt++;
    end
    chk("t4_lo2", obs_lo, 100);
    chk("t4_done2_cnt", done_cnt, 1);

    // 5: reset mid-multiply aborts
    cycle(1'b1, 1'b1, 2'b00, 32'd5, 32'd5, 1'b1);
    idle(9);
    cycle(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (obs_busy) busy_cnt++;
      if (obs_done) done_cnt++;
    end
    chk("t5_busy", busy_cnt, 0);
    chk("t5_done", done_cnt, 0);
    chk("t5_hi", obs_hi, 0);
    chk("t5_lo", obs_lo, 0);

    // 6: no accept without issue; independent ops never stall
    cycle(1'b0, 1'b1, 2'b00, 32'd9, 32'd9, 1'b1);
    idle(1);
    chk("t6_no_accept", obs_busy, 0);
    cycle(1'b1, 1'b1, 2'b00, 32'd9, 32'd9, 1'b1);
    cycle(1'b1, 1'b0, 2'b00, 32'd1, 32'd2, 1'b1);
    chk("t6_add_stall", obs_stall, 0);
    cycle(1'b1, 1'b0, 2'b11, 32'd1, 32'd2, 1'b1);
    chk("t6_rsvd_stall", obs_stall, 0);
    idle(W + 2);
    chk("t6_lo", obs_lo, 81);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
            pick(), pick(), $urandom_range(0, 299) != 0);
    end
    idle(W + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
